// File: rtl/wr_ctrl_sync.sv
// Write-side controller for the dual-clock FIFO: binary/Gray write pointers,
// read-pointer synchroniser, full/almost-full/level and sticky overflow.
module wr_ctrl_sync #(
    parameter int ADDR_WIDTH  = 4,  // >= 2
    parameter int SYNC_STAGES = 2   // >= 2
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  winc,
    input  logic                  wclr_ovf,
    input  logic [ADDR_WIDTH:0]   afull_thresh,
    input  logic [ADDR_WIDTH:0]   r_ptr,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   w_ptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    localparam int AW = ADDR_WIDTH;
    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]                  wbin;
    logic [PW-1:0]                  wbin_next;
    logic [PW-1:0]                  wgray_next;
    logic [SYNC_STAGES-1:0][PW-1:0] rsync;
    logic [PW-1:0]                  rq;
    logic [PW-1:0]                  rbin_s;
    logic [PW-1:0]                  full_cmp;
    logic [PW-1:0]                  level_next;
    logic                           full_next;
    logic                           afull_next;

    // r_ptr is only ever sampled by the first synchroniser stage
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst)
            rsync <= '0;
        else
            rsync <= {rsync[SYNC_STAGES-2:0], r_ptr};
    end

    assign rq = rsync[SYNC_STAGES-1];

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_g2b
            assign rbin_s[gi] = ^rq[PW-1:gi];
        end
    endgenerate

    assign wen        = winc & ~wfull;
    assign waddr      = wbin[AW-1:0];
    assign wbin_next  = wbin + PW'(wen);
    assign wgray_next = wbin_next ^ (wbin_next >> 1);

    // Full when the write pointer is exactly one lap ahead of the synced read pointer
    assign full_cmp   = {~rq[AW:AW-1], rq[AW-2:0]};
    assign full_next  = (wgray_next == full_cmp);
    assign level_next = wbin_next - rbin_s;
    assign afull_next = (afull_thresh != '0) && (level_next >= afull_thresh);

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            wbin         <= '0;
            w_ptr        <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            w_ptr        <= wgray_next;
            wfull        <= full_next;
            walmost_full <= afull_next;
            wlevel       <= level_next;
            // a new overflow outranks a simultaneous clear
            if (winc && wfull)
                woverflow <= 1'b1;
            else if (wclr_ovf)
                woverflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wr_ctrl_sync.sv
// Bench for wr_ctrl_sync: directed phases plus randomized write/read traffic
// checked against a count-based occupancy model.
module tb_wr_ctrl_sync;

    localparam int AW    = 4;
    localparam int SS    = 2;
    localparam int DEPTH = 1 << AW;

    logic          w_clk;
    logic          w_rst;
    logic          winc;
    logic          wclr_ovf;
    logic [AW:0]   afull_thresh;
    logic [AW:0]   r_ptr;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [AW:0]   w_ptr;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wlevel;
    logic          woverflow;

    int checks   = 0;
    int failures = 0;

    // model: total accepted writes, total reads, reads as seen after sync delay
    int m_wcnt;
    int rd_cnt;
    int m_sync [SS];
    int m_level;
    bit m_full;
    bit m_afull;
    bit m_ovf;

    wr_ctrl_sync #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
        .w_clk(w_clk), .w_rst(w_rst), .winc(winc), .wclr_ovf(wclr_ovf),
        .afull_thresh(afull_thresh), .r_ptr(r_ptr), .wen(wen), .waddr(waddr),
        .w_ptr(w_ptr), .wfull(wfull), .walmost_full(walmost_full),
        .wlevel(wlevel), .woverflow(woverflow)
    );

    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    function automatic logic [AW:0] gray(input int v);
        logic [AW:0] b;
        b = v[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wcnt  = 0;
        rd_cnt  = 0;
        for (int i = 0; i < SS; i++) m_sync[i] = 0;
        m_level = 0;
        m_full  = 1'b0;
        m_afull = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // one clock: check combinational outputs, step model at the edge, check registers
    task automatic tick();
        bit exp_wen;
        int old_rq;
        #1;
        exp_wen = winc && !m_full;
        chk("wen", wen, exp_wen);
        chk("waddr", waddr, m_wcnt % DEPTH);
        @(posedge w_clk);
        old_rq = m_sync[SS-1];
        if (winc && m_full)  m_ovf = 1'b1;
        else if (wclr_ovf)   m_ovf = 1'b0;
        if (exp_wen) m_wcnt++;
        m_level = (m_wcnt - old_rq) % (2 * DEPTH);
        m_full  = (m_level == DEPTH);
        m_afull = (afull_thresh != 0) && (m_level >= int'(afull_thresh));
        for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = rd_cnt;
        #1;
        chk("wfull", wfull, m_full);
        chk("wlevel", wlevel, m_level);
        chk("walmost_full", walmost_full, m_afull);
        chk("woverflow", woverflow, m_ovf);
        chk("w_ptr", w_ptr, gray(m_wcnt));
    endtask

    task automatic pulse_reset();
        w_rst = 1'b0;
        #2;
        w_rst = 1'b1;
        model_reset();
        r_ptr = gray(rd_cnt);
    endtask

    initial begin
        logic [AW:0] prev_ptr;
        int          had;
        int          cyc;
        int          occ;

        // reset held with activity on the inputs
        w_rst = 1'b0; winc = 1'b1; wclr_ovf = 1'b0;
        afull_thresh = 5'd12; r_ptr = 5'b10110;
        model_reset();
        repeat (3) @(posedge w_clk);
        #1;
        chk("rst_w_ptr", w_ptr, 0);
        chk("rst_wlevel", wlevel, 0);
        chk("rst_wfull", wfull, 0);
        chk("rst_woverflow", woverflow, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wen", wen, 1);
        r_ptr = 5'b00000;
        w_rst = 1'b1;

        // fill from empty with threshold 12
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_waddr", waddr, i);
            tick();
            chk("fill_afull_edge", walmost_full, (i >= 11));
            chk("fill_full_edge", wfull, (i == DEPTH - 1));
        end
        chk("fill_w_ptr", w_ptr, 5'b11000);
        chk("fill_wlevel", wlevel, DEPTH);

        // overflow while full, then clear semantics
        winc = 1'b1;
        repeat (3) tick();
        chk("ovf_set", woverflow, 1);
        chk("ovf_w_ptr_hold", w_ptr, 5'b11000);
        winc = 1'b0; wclr_ovf = 1'b1;
        tick();
        chk("ovf_cleared", woverflow, 0);
        winc = 1'b1;
        tick();
        chk("ovf_set_beats_clr", woverflow, 1);
        winc = 1'b0;
        tick();
        wclr_ovf = 1'b0;

        // a single read becomes visible SS+1 edges later
        rd_cnt = 1;
        r_ptr  = gray(rd_cnt);
        tick();
        tick();
        chk("drain_still_full", wfull, 1);
        tick();
        chk("drain_wfull", wfull, 0);
        chk("drain_wlevel", wlevel, DEPTH - 1);
        winc = 1'b1;
        #1;
        chk("drain_wen", wen, 1);
        chk("drain_waddr", waddr, 0);
        tick();
        winc = 1'b0;

        // random traffic across pointer wrap, true occupancy kept <= 8
        pulse_reset();
        cyc = 0;
        while (m_wcnt < 40 && cyc < 1000) begin
            occ  = m_wcnt - rd_cnt;
            winc = (occ < 8) && ($urandom_range(0, 3) != 0);
            if (rd_cnt < m_wcnt && $urandom_range(0, 1) == 1) rd_cnt++;
            r_ptr = gray(rd_cnt);
            if ($urandom_range(0, 7) == 0) afull_thresh = 5'($urandom_range(0, 12));
            prev_ptr = w_ptr;
            had      = m_wcnt;
            tick();
            chk("wrap_one_bit", $countones(w_ptr ^ prev_ptr), (m_wcnt != had) ? 1 : 0);
            chk("wrap_no_full", wfull, 0);
            if (m_wcnt == 32 && had == 31) chk("wrap_ptr_zero", w_ptr, 0);
            cyc++;
        end
        chk("wrap_done_in_budget", (m_wcnt >= 40), 1);
        winc = 1'b0;

        // asynchronous reset in the middle of a fill
        afull_thresh = 5'd12;
        pulse_reset();
        winc = 1'b1;
        repeat (7) tick();
        winc = 1'b0;
        chk("mid_w_ptr_pre", w_ptr, gray(7));
        #2;
        w_rst = 1'b0;
        #1;
        chk("mid_rst_w_ptr", w_ptr, 0);
        chk("mid_rst_wlevel", wlevel, 0);
        chk("mid_rst_waddr", waddr, 0);
        chk("mid_rst_wfull", wfull, 0);
        chk("mid_rst_afull", walmost_full, 0);
        chk("mid_rst_ovf", woverflow, 0);
        w_rst = 1'b1;
        model_reset();
        r_ptr = gray(rd_cnt);
        winc  = 1'b1;
        #1;
        chk("mid_restart_waddr", waddr, 0);
        tick();
        tick();
        winc = 1'b0;
        chk("mid_restart_w_ptr", w_ptr, gray(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wr_ctrl_sync.md
Name: wr_ctrl_sync

Overview:
- Parametrised write-side controller for the dual-clock FIFO; next generation of the write pointer/full-flag block.
- Owns the binary and Gray write pointers, the memory write strobe and address, and an internal SYNC_STAGES-deep synchroniser for the read-domain Gray pointer.
- Adds a fill-level output, a programmable almost-full flag and a sticky overflow flag with clear.
- Sits between the write-side client, the dual-port RAM and the read controller.

Parameters:
- ADDR_WIDTH, 4: memory address width. Depth DEPTH = 2^ADDR_WIDTH. Minimum 2.
- SYNC_STAGES, 2: flops in the r_ptr synchroniser. Minimum 2.

Ports:
- w_clk  input  1  write-domain clock.
- w_rst  input  1  asynchronous reset, active-low.
- winc  input  1  write request from client.
- wclr_ovf  input  1  synchronous clear of woverflow.
- afull_thresh  input  ADDR_WIDTH+1  almost-full level threshold. 0 disables the flag.
- r_ptr  input  ADDR_WIDTH+1  read Gray pointer from the read domain, asynchronous to w_clk.
- wen  output  1  RAM write enable.
- waddr  output  ADDR_WIDTH  RAM write address.
- w_ptr  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- wfull  output  1  FIFO full, registered.
- walmost_full  output  1  level >= afull_thresh, registered.
- wlevel  output  ADDR_WIDTH+1  fill level 0..DEPTH, registered.
- woverflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (w_rst low, asynchronous):
  - All pointers and synchroniser flops go to 0.
  - wfull=0, walmost_full=0, wlevel=0, woverflow=0.
  - w_ptr=0, waddr=0.
  - wen follows its combinational rule, so wen=winc.
  - Release is synchronous to the next w_clk edge.
- Accept: wen = winc & ~wfull. This is combinational; the write is accepted in the same cycle.
- Address: waddr = wbin[ADDR_WIDTH-1:0], taken from the registered binary pointer.
- Pointer update:
  - wbin_next = wbin + wen, modulo 2^(ADDR_WIDTH+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1), computed over the full width including the MSB.
  - wbin and w_ptr are both registered from these next values on the same edge.
  - w_ptr therefore changes one bit per accepted write and never glitches.
- Synchroniser:
  - r_ptr passes through SYNC_STAGES flops to give rq.
  - rq is converted Gray-to-binary (MSB-first XOR cascade) to give rbin_s.
  - No other logic samples r_ptr directly.
- Full: wfull <= (wgray_next == {~rq[AW:AW-1], rq[AW-2:0]}), where AW = ADDR_WIDTH.
  - wfull rises on the edge that stores the DEPTH-th unread word.
- Level: wlevel <= wbin_next - rbin_s, modulo 2^(ADDR_WIDTH+1).
  - wlevel == DEPTH exactly when wfull is set.
  - The level is pessimistic: it lags reads by up to SYNC_STAGES+1 w_clk cycles and never under-reports.
- Almost-full: walmost_full <= (afull_thresh != 0) && (level_next >= afull_thresh).
  - Updates on the same edge as wlevel.
  - A change to afull_thresh takes effect on the next edge.
- Overflow:
  - If winc & wfull: no write (wen=0), pointers hold, woverflow <= 1.
  - wclr_ovf clears woverflow to 0.
  - A set in the same cycle as a clear wins (woverflow=1).
- Wrap: the pointer MSB toggles every DEPTH writes. The full/empty distinction relies on MSB plus second-MSB inversion in Gray code.
- Simultaneous write and read-pointer advance: both are reflected in the same next-state computation. wfull may be deasserted while wen is high, and the level stays consistent.
- Deassertion of full: wfull drops SYNC_STAGES+1 cycles after r_ptr changes, with no further writes.
- Reset mid-operation: all state returns to reset values immediately. The read side must be reset concurrently; this block does not coordinate that.

Test Plan:
- Reset: hold w_rst=0 with winc=1 and r_ptr=5'b10110 -> w_ptr=0, wlevel=0, wfull=0, woverflow=0, waddr=0. After release, first accepted write has waddr=0.
- Fill (r_ptr=0, afull_thresh=12, 16 back-to-back winc):
  - walmost_full goes 1 on the edge after the 12th write.
  - wfull=1 and wlevel=16 on the edge after the 16th write.
  - w_ptr=5'b11000; waddr cycled 0..15.
- Overflow: from full, winc=1 for 3 cycles -> wen=0, waddr=0, w_ptr unchanged, woverflow=1. Pulse wclr_ovf with winc=0 -> woverflow=0. Assert wclr_ovf together with winc while full -> woverflow stays 1.
- Drain visibility: from full, set r_ptr=5'b00001 (read count 1) -> wfull=0 and wlevel=15 exactly SYNC_STAGES+1=3 edges later; the next winc is accepted with waddr=0.
- Wrap: 40 writes with a reader model keeping the level <= 8 -> every w_ptr change flips exactly one bit, w_ptr returns to 0 after 32 writes, and wfull never asserts.
- Reset mid-fill: after 7 writes, pulse w_rst low asynchronously between edges -> outputs return to reset values before the next w_clk edge, and writes restart at waddr=0.
